alu_mc: RTL
===========

# alu_mc

Multi-cycle, parametrised integer ALU with valid/ready handshakes on operand and result sides. It replaces the single-cycle combinational ALU in the execute stage. Shift, add/sub, logic and compare ops finish in one cycle; multiply and divide run iteratively, one bit per cycle. All outputs are registered, so result timing is independent of the multiplier and divider depth.

## Interface
- `WIDTH`, 32: operand/result width; power of two, at least 8.
- `SHW`, $clog2(WIDTH): shift-amount width, derived; do not override.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands and op are valid.
- `in_ready` output 1: ALU can accept an operation.
- `a`, `b` input WIDTH: operands.
- `op` input 4: opcode (encoding below).
- `out_valid` output 1: result registers hold a completed operation.
- `out_ready` input 1: consumer accepts the result.
- `result1` output WIDTH: primary result; low half for MUL, quotient for DIV.
- `result2` output WIDTH: high half for MUL, remainder for DIV, 0 for all other ops.
- `eq` output 1: registered (a == b) of the accepted operation.
- `lesser`, `greater_eq` output 1: compare flags; set only by SLT and SLTU, 0 for all other ops.
- `illegal` output 1: opcode was undefined or is compiled out.

## Operation
- Opcodes:
  - 0000 SLL, 0001 SRA, 0010 SRL: shift amount is b[SHW-1:0].
  - 0011 MUL: unsigned, 2·WIDTH-bit product.
  - 0100 DIV: unsigned, quotient and remainder.
  - 0101 ADD, 0110 SUB, 0111 AND, 1000 OR, 1001 XOR, 1010 NOR.
  - 1011 SLT (signed), 1100 SLTU (unsigned).
  - 1101–1111: undefined.
- ADD/SUB wrap modulo 2^WIDTH.
- SLT/SLTU: result1 = 1 when a < b, else 0; `lesser` = result1[0]; `greater_eq` = ~`lesser`.
- Undefined op: result1 = result2 = 0, `illegal` = 1; completes in one cycle.
- FSM states: IDLE, BUSY, DONE.
  - IDLE→DONE: accepted single-cycle op.
  - IDLE→BUSY: accepted MUL/DIV; a and b are latched, iteration counter loaded with WIDTH.
  - BUSY→DONE: counter reaches 0.
  - DONE→IDLE: out_valid && out_ready.
- MUL: shift-add, one multiplier bit per cycle.
- DIV: restoring, one quotient bit per cycle.
- Divide by zero: still takes WIDTH cycles; quotient = all ones, remainder = a.
- Operands are latched at acceptance; changes to a, b or op afterwards do not affect the operation in flight.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, result1 = result2 = 0, all flags = 0, state = IDLE.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- `in_ready` = (state == IDLE), so only one operation is in flight.
- Latency, with acceptance on edge N:
  - Single-cycle op: `out_valid` rises after edge N+1.
  - MUL/DIV: `out_valid` rises after edge N+WIDTH+1.
- In DONE, all outputs are held stable until out_ready; out_ready is ignored when out_valid = 0.
- `rst_n` asserted mid-operation aborts immediately; no result is produced and outputs return to reset values.
- Back-to-back throughput for single-cycle ops is one op per 2 cycles (accept, then drain).

## Configuration
- `ALU_MULDIV_EN` defined:
  - MUL and DIV hardware (counter, BUSY path, partial product/remainder registers) is built as described.
- `ALU_MULDIV_EN` undefined:
  - MUL/DIV logic is removed and BUSY is unreachable.
  - Opcodes 0011 and 0100 are treated as undefined: one-cycle completion, results 0, `illegal` = 1.

## Test plan
- Reset, then SUB with a=5, b=7 and out_ready=1 → out_valid one cycle after acceptance; result1=0xFFFFFFFE, result2=0, eq=0, illegal=0.
- SRA with a=0x80000000, b=0x24 → shift amount 4; result1=0xF8000000.
- SLT with a=0xFFFFFFFF, b=1 → result1=1, lesser=1, greater_eq=0. SLTU with the same operands → result1=0, lesser=0, greater_eq=1.
- MUL with a=0xFFFFFFFF, b=2:
  - in_ready stays low for 32 cycles.
  - out_valid rises 33 cycles after acceptance with result2=1, result1=0xFFFFFFFE.
  - Hold out_ready=0 for 5 cycles → outputs stay stable.
- DIV with a=100, b=7 → result1=14, result2=2. DIV with a=9, b=0 → result1=0xFFFFFFFF, result2=9.
- Pull rst_n low 10 cycles into a DIV → out_valid=0 and in_ready=1 immediately. Then op=1110 → result1=0, illegal=1. Build without ALU_MULDIV_EN, op=0011 → illegal=1 after one cycle.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with valid/ready handshakes on both sides; all outputs registered.
// Define ALU_MULDIV_EN to build the iterative MUL/DIV datapath; otherwise 0011/0100 are illegal.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result1,
  output logic [WIDTH-1:0] result2,
  output logic             eq,
  output logic             lesser,
  output logic             greater_eq,
  output logic             illegal
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready high
  // BUSY  | MUL/DIV iterating, one bit per cycle
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRA  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result1_q, result1_d;
  logic [WIDTH-1:0] result2_q, result2_d;
  logic             eq_q, eq_d;
  logic             lesser_q, lesser_d;
  logic             greater_eq_q, greater_eq_d;
  logic             illegal_q, illegal_d;

  logic [SHW-1:0]   shamt;
  logic             slt_s, slt_u;

  assign shamt = b[SHW-1:0];
  assign slt_s = $signed(a) < $signed(b);
  assign slt_u = a < b;

`ifdef ALU_MULDIV_EN
  // While BUSY, result2/result1 double as {high, low} product or {remainder, quotient}.
  logic [WIDTH-1:0] b_q, b_d;
  logic             is_div_q, is_div_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_take;

  assign mul_sum   = {1'b0, result2_q} + (result1_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {result2_q, result1_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  // Divisor zero always "fits", which gives all-ones quotient and remainder = a.
  assign div_take  = div_shift >= {1'b0, b_q};
`endif

  always_comb begin
    state_d      = state_q;
    result1_d    = result1_q;
    result2_d    = result2_q;
    eq_d         = eq_q;
    lesser_d     = lesser_q;
    greater_eq_d = greater_eq_q;
    illegal_d    = illegal_q;
`ifdef ALU_MULDIV_EN
    b_d          = b_q;
    is_div_d     = is_div_q;
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d      = S_DONE;
          result1_d    = '0;
          result2_d    = '0;
          eq_d         = (a == b);
          lesser_d     = 1'b0;
          greater_eq_d = 1'b0;
          illegal_d    = 1'b0;
          case (op)
            OP_SLL:  result1_d = a << shamt;
            OP_SRA:  result1_d = $signed(a) >>> shamt;
            OP_SRL:  result1_d = a >> shamt;
            OP_ADD:  result1_d = a + b;
            OP_SUB:  result1_d = a - b;
            OP_AND:  result1_d = a & b;
            OP_OR:   result1_d = a | b;
            OP_XOR:  result1_d = a ^ b;
            OP_NOR:  result1_d = ~(a | b);
            OP_SLT: begin
              result1_d    = {{(WIDTH-1){1'b0}}, slt_s};
              lesser_d     = slt_s;
              greater_eq_d = ~slt_s;
            end
            OP_SLTU: begin
              result1_d    = {{(WIDTH-1){1'b0}}, slt_u};
              lesser_d     = slt_u;
              greater_eq_d = ~slt_u;
            end
`ifdef ALU_MULDIV_EN
            OP_MUL, OP_DIV: begin
              state_d   = S_BUSY;
              result1_d = a;
              b_d       = b;
              is_div_d  = (op == OP_DIV);
              cnt_d     = (SHW+1)'(WIDTH);
            end
`endif
            default: illegal_d = 1'b1;
          endcase
        end
      end
      S_BUSY: begin
`ifdef ALU_MULDIV_EN
        if (is_div_q) begin
          result2_d = div_take ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          result1_d = {result1_q[WIDTH-2:0], div_take};
        end else begin
          {result2_d, result1_d} = {mul_sum, result1_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == (SHW+1)'(1))
          state_d = S_DONE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      result1_q    <= '0;
      result2_q    <= '0;
      eq_q         <= 1'b0;
      lesser_q     <= 1'b0;
      greater_eq_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      result1_q    <= result1_d;
      result2_q    <= result2_d;
      eq_q         <= eq_d;
      lesser_q     <= lesser_d;
      greater_eq_q <= greater_eq_d;
      illegal_q    <= illegal_d;
    end
  end

`ifdef ALU_MULDIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q      <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      b_q      <= b_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign result1    = result1_q;
  assign result2    = result2_q;
  assign eq         = eq_q;
  assign lesser     = lesser_q;
  assign greater_eq = greater_eq_q;
  assign illegal    = illegal_q;

endmodule
